// File: rtl/tt6581_pkg.sv
// Shared widths and the mixer state type for the voice mixer and the blocks around it.
package tt6581_pkg;

    localparam int VOICE_W  = 12;
    localparam int ENV_W    = 8;
    localparam int VOL_W    = 4;
    localparam int SAMPLE_W = 16;

    localparam int MULT_A_W = 24;
    localparam int MULT_B_W = 16;
    localparam int MULT_P_W = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_ISSUE,
        ST_V_WAIT,
        ST_VOL_ISSUE,
        ST_VOL_WAIT,
        ST_DONE
    } mix_state_e;

endpackage

// File: rtl/voice_mixer.sv
// Per-tick voice mixer: one shared-multiplier pass per voice (sample x envelope),
// then one pass of the accumulated sum by master volume.
module voice_mixer
    import tt6581_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int OUT_SHIFT  = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          sample_tick_i,
    input  logic [NUM_VOICES*VOICE_W-1:0] voices_i,
    input  logic [NUM_VOICES*ENV_W-1:0]   envs_i,
    input  logic [VOL_W-1:0]              volume_i,
    output logic                          mult_start_o,
    output logic [MULT_A_W-1:0]           mult_op_a_o,
    output logic [MULT_B_W-1:0]           mult_op_b_o,
    input  logic                          mult_ready_i,
    input  logic [MULT_P_W-1:0]           mult_prod_i,
    output logic [SAMPLE_W-1:0]           sample_o,
    output logic                          sample_valid_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int ACC_W = 22;
    localparam int IDX_W = $clog2(NUM_VOICES + 1);

    mix_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [SAMPLE_W-1:0]           sample_q, sample_d;
    logic                          first_q, first_d;
    logic [NUM_VOICES*VOICE_W-1:0] voices_q;
    logic [NUM_VOICES*ENV_W-1:0]   envs_q;
    logic [VOL_W-1:0]              vol_q;
    logic                          snap_en;

    logic [VOICE_W-1:0]            cur_voice;
    logic [ENV_W-1:0]              cur_env;
    logic [MULT_A_W-1:0]           voice_op_a, vol_op_a;
    logic [MULT_B_W-1:0]           voice_op_b, vol_op_b;
    logic                          unused_prod_bits;

    assign cur_voice  = voices_q[idx_q*VOICE_W +: VOICE_W];
    assign cur_env    = envs_q[idx_q*ENV_W +: ENV_W];
    assign voice_op_a = {{(MULT_A_W-VOICE_W){cur_voice[VOICE_W-1]}}, cur_voice};
    assign voice_op_b = {{(MULT_B_W-ENV_W){1'b0}}, cur_env};
    assign vol_op_a   = {{(MULT_A_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign vol_op_b   = {{(MULT_B_W-VOL_W){1'b0}}, vol_q};

    // Only the low bits of each product carry information; the rest are sign copies.
    assign unused_prod_bits = ^mult_prod_i[MULT_P_W-1:OUT_SHIFT+SAMPLE_W];

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        sample_d     = sample_q;
        first_d      = 1'b0;
        snap_en      = 1'b0;
        mult_start_o = 1'b0;
        mult_op_a_o  = '0;
        mult_op_b_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick_i) begin
                    snap_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_V_ISSUE;
                end
            end
            ST_V_ISSUE: begin
                mult_op_a_o = voice_op_a;
                mult_op_b_o = voice_op_b;
                if (mult_ready_i) begin
                    mult_start_o = 1'b1;
                    first_d      = 1'b1;
                    state_d      = ST_V_WAIT;
                end
            end
            ST_V_WAIT: begin
                mult_op_a_o = voice_op_a;
                mult_op_b_o = voice_op_b;
                // Ready may still read high in the cycle right after start.
                if (!first_q && mult_ready_i) begin
                    acc_d = acc_q + $signed(mult_prod_i[ACC_W-1:0]);
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                        state_d = ST_VOL_ISSUE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_V_ISSUE;
                    end
                end
            end
            ST_VOL_ISSUE: begin
                mult_op_a_o = vol_op_a;
                mult_op_b_o = vol_op_b;
                if (mult_ready_i) begin
                    mult_start_o = 1'b1;
                    first_d      = 1'b1;
                    state_d      = ST_VOL_WAIT;
                end
            end
            ST_VOL_WAIT: begin
                mult_op_a_o = vol_op_a;
                mult_op_b_o = vol_op_b;
                if (!first_q && mult_ready_i) begin
                    sample_d = mult_prod_i[OUT_SHIFT+SAMPLE_W-1:OUT_SHIFT];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            first_q  <= 1'b0;
            voices_q <= '0;
            envs_q   <= '0;
            vol_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            first_q  <= first_d;
            if (snap_en) begin
                voices_q <= voices_i;
                envs_q   <= envs_i;
                vol_q    <= volume_i;
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign overrun_o      = sample_tick_i && busy_o;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a behavioural shared multiplier of latency 16.
module tb_voice_mixer;

    localparam int L = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_tick_i = 1'b0;
    logic [35:0]        voices_i = '0;
    logic [23:0]        envs_i = '0;
    logic [3:0]         volume_i = '0;
    logic               mult_start;
    logic signed [23:0] mult_op_a;
    logic signed [15:0] mult_op_b;
    logic               mult_ready;
    logic signed [39:0] mult_prod;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;
    int valid_cnt = 0;
    int overrun_cnt = 0;
    int stable_err = 0;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(3), .OUT_SHIFT(10)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_tick_i  (sample_tick_i),
        .voices_i       (voices_i),
        .envs_i         (envs_i),
        .volume_i       (volume_i),
        .mult_start_o   (mult_start),
        .mult_op_a_o    (mult_op_a),
        .mult_op_b_o    (mult_op_b),
        .mult_ready_i   (mult_ready),
        .mult_prod_i    (mult_prod),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    // Start in cycle c drops ready in c+1 and raises it with the product in c+L.
    logic signed [23:0] a_lat;
    logic signed [15:0] b_lat;
    int                 m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_ready <= 1'b1;
            mult_prod  <= '0;
            m_cnt      <= 0;
            a_lat      <= '0;
            b_lat      <= '0;
        end else if (mult_ready) begin
            if (mult_start) begin
                mult_ready <= 1'b0;
                m_cnt      <= L - 2;
                a_lat      <= mult_op_a;
                b_lat      <= mult_op_b;
            end
        end else if (m_cnt == 0) begin
            mult_ready <= 1'b1;
            mult_prod  <= a_lat * b_lat;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (mult_start)   start_cnt   <= start_cnt + 1;
        if (sample_valid) valid_cnt   <= valid_cnt + 1;
        if (overrun)      overrun_cnt <= overrun_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n && !mult_ready && (mult_op_a !== a_lat || mult_op_b !== b_lat))
            stable_err <= stable_err + 1;
    end

    task automatic check(input string tag, input logic signed [39:0] obs, input logic signed [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Cycle numbering counts the tick cycle as 1; returns
    // the number of the cycle in which sample_valid_o is seen.
    task automatic mix(input logic [35:0] v, input logic [23:0] e, input logic [3:0] vol,
                       input bit mid_tick, input logic [35:0] alt_v, input bit done_tick,
                       output int cyc);
        voices_i = v;
        envs_i = e;
        volume_i = vol;
        sample_tick_i = 1'b1;
        cyc = 1;
        while (1) begin
            @(negedge clk);
            sample_tick_i = 1'b0;
            cyc++;
            if (mid_tick && cyc == 10) begin
                voices_i = alt_v;
                sample_tick_i = 1'b1;
            end
            if (sample_valid) break;
            if (cyc > 300) begin
                vectors++;
                miscompares++;
                $error("FAIL valid_timeout: observed no strobe within %0d cycles, required strobe", cyc);
                break;
            end
        end
        if (done_tick) sample_tick_i = 1'b1;
        @(negedge clk);
        sample_tick_i = 1'b0;
    endtask

    int cyc;
    int s0, v0, o0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start", mult_start, 0);
        check("rst_overrun", overrun, 0);
        check("rst_op_a", mult_op_a, 0);
        check("rst_op_b", mult_op_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single full-scale positive voice.
        s0 = start_cnt; v0 = valid_cnt;
        mix({12'd0, 12'd0, 12'd2047}, {8'd0, 8'd0, 8'd255}, 4'd15, 0, '0, 0, cyc);
        check("s1_sample", sample, 7646);
        check("s1_latency", cyc, 70);
        check("s1_valid_pulses", valid_cnt - v0, 1);
        check("s1_starts", start_cnt - s0, 4);
        repeat (5) @(negedge clk);
        check("s1_hold", sample, 7646);
        check("s1_idle", busy, 0);

        // Most negative voice: floor shift stays exact.
        mix({12'd0, 12'd0, 12'h800}, {8'd0, 8'd0, 8'd255}, 4'd15, 0, '0, 0, cyc);
        check("s2_sample", sample, -7650);

        // All voices full scale.
        mix({12'd2047, 12'd2047, 12'd2047}, {8'd255, 8'd255, 8'd255}, 4'd15, 0, '0, 0, cyc);
        check("s3_sample", sample, 22938);

        // Zero volume still runs the full sequence.
        s0 = start_cnt; v0 = valid_cnt;
        mix({12'd300, 12'd200, 12'd100}, {8'd30, 8'd20, 8'd10}, 4'd0, 0, '0, 0, cyc);
        check("s4_sample", sample, 0);
        check("s4_valid_pulses", valid_cnt - v0, 1);
        check("s4_starts", start_cnt - s0, 4);

        // Tick and new voices mid-mix: snapshot must win.
        o0 = overrun_cnt;
        mix({12'd0, 12'd0, 12'd2047}, {8'd0, 8'd0, 8'd255}, 4'd15, 1, {12'd0, 12'd0, 12'hC18}, 0, cyc);
        check("s5_overrun", overrun_cnt - o0, 1);
        check("s5_sample", sample, 7646);
        mix({12'd0, 12'd0, 12'hC18}, {8'd0, 8'd0, 8'd255}, 4'd15, 0, '0, 0, cyc);
        check("s5_new_sample", sample, -3736);

        // Tick landing in the DONE cycle is an overrun, not a new mix.
        o0 = overrun_cnt; v0 = valid_cnt;
        mix({12'd0, 12'd0, 12'd2047}, {8'd0, 8'd0, 8'd255}, 4'd15, 0, '0, 1, cyc);
        repeat (5) @(negedge clk);
        check("done_overrun", overrun_cnt - o0, 1);
        check("done_no_remix", busy, 0);
        check("done_valid_pulses", valid_cnt - v0, 1);

        // Smallest negative product floors to -1.
        mix({12'd0, 12'd0, 12'hFFF}, {8'd0, 8'd0, 8'd1}, 4'd1, 0, '0, 0, cyc);
        check("floor_sample", sample, -1);

        // Asynchronous reset in the middle of a voice wait.
        voices_i = {12'd0, 12'd0, 12'd2047};
        envs_i = {8'd0, 8'd0, 8'd255};
        volume_i = 4'd15;
        sample_tick_i = 1'b1;
        @(negedge clk);
        sample_tick_i = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sample", sample, 0);
        check("arst_busy", busy, 0);
        check("arst_start", mult_start, 0);
        check("arst_op_a", mult_op_a, 0);
        check("arst_op_b", mult_op_b, 0);
        check("arst_valid", sample_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mix({12'd0, 12'd0, 12'd2047}, {8'd0, 8'd0, 8'd255}, 4'd15, 0, '0, 0, cyc);
        check("post_rst_sample", sample, 7646);
        check("post_rst_latency", cyc, 70);

        check("operand_stability", stable_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
